output_write_scheduler: RTL
===========================

Name: output_write_scheduler

Overview:
Sequences all writes of convolution results into the output SRAM write port.
- Accepts 16-bit result words from the convolution datapath over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one SRAM write per cycle, only when the shared SRAM port is granted, at incrementing addresses from a run base address.
- Drains after the end-of-run signal and pulses done, so the top-level controller can clear busy.

Parameters:
DATA_W, 16, result word and SRAM data width
ADDR_W, 12, SRAM address width
DEPTH, 4, FIFO depth in words (power of two, >= 2)

Ports:
clk  input  1  clock, rising edge
reset_b  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run, latches base_addr
base_addr  input  ADDR_W  address of the first output word of the run
res_valid  input  1  datapath presents a result word
res_data  input  DATA_W  result word
res_ready  output  1  scheduler accepts the word this cycle
run_end  input  1  one-cycle pulse; datapath will produce no further results this run
sram_grant  input  1  output SRAM port may be written this cycle
dut_sram_write_enable  output  1  registered write strobe
dut_sram_write_address  output  ADDR_W  registered write address
dut_sram_write_data  output  DATA_W  registered write data
wr_count  output  ADDR_W  words written this run
busy  output  1  run in progress
done  output  1  one-cycle pulse; run finished and all words written
addr_wrap  output  1  sticky; write address wrapped past all-ones this run

Behaviour:
- Reset (async, reset_b=0):
  - state=IDLE; FIFO emptied.
  - All outputs 0, including write enable/address/data, wr_count, busy, done, addr_wrap, res_ready.
- States IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN. On that edge: next_addr<=base_addr, wr_count<=0, addr_wrap<=0, busy<=1.
  - RUN: run_end -> DRAIN.
  - DRAIN: FIFO empty -> DONE.
  - DONE: always returns to IDLE next cycle. done=1 and busy=1 during DONE; busy=0 from IDLE onward.
- Ignored inputs:
  - start outside IDLE has no effect.
  - run_end outside RUN has no effect.
- res_ready is registered and equals (state==RUN and FIFO count after this edge < DEPTH).
  - A word is pushed only when res_valid & res_ready.
  - A simultaneous pop does not raise res_ready in the same cycle, so no push occurs into a full FIFO.
  - res_valid while res_ready=0 leaves res_data unaccepted; the datapath must hold it.
- Pop/write condition at an edge: FIFO non-empty & sram_grant & state in {RUN, DRAIN}. On that edge:
  - dut_sram_write_enable<=1, dut_sram_write_address<=next_addr, dut_sram_write_data<=FIFO head.
  - next_addr<=next_addr+1, wr_count<=wr_count+1.
  - Otherwise dut_sram_write_enable<=0; address and data hold their last values.
- Latency: a word pushed at edge k into an empty FIFO with sram_grant high appears on the write outputs after edge k+1. That is 2 cycles from res_valid sampled to write strobe visible.
- Order: words are written strictly in acceptance order, no gaps in the address sequence.
- sram_grant low stalls writes only. The FIFO keeps accepting until full.
- Address wrap: next_addr wraps modulo 2^ADDR_W. On the write whose address is all-ones, addr_wrap<=1. addr_wrap stays set until the next start.
- run_end in the same cycle as a push: the word is accepted, then the state goes to DRAIN.
- run_end when the FIFO is already empty and no write is pending: DRAIN lasts one cycle, then DONE.
- DONE is entered only after the last write strobe has been issued. done may coincide with that last strobe's visible cycle or follow it; it never precedes it.
- wr_count wraps modulo 2^ADDR_W.

Decomposition:
- Shared package: state enum (IDLE, RUN, DRAIN, DONE); ADDR_W and DATA_W constants; the run base-address constant (12'h0) used by the top level.
- One natural sub-module: sync_fifo (parameterised DATA_W/DEPTH, push/pop, full, empty, count, async active-low reset).

Test Plan:
- Basic run: start with base_addr=0x010, 3 words 0xAAAA, 0x5555, 0x1234 back-to-back, grant=1, then run_end -> writes to 0x010, 0x011, 0x012 in order; first strobe 2 cycles after the first valid; wr_count=3; done pulses once; busy falls after done.
- Backpressure: grant=0 for 10 cycles while valid is held high -> exactly 4 words accepted, res_ready=0; grant=1 -> 4 consecutive writes; then streaming resumes with no loss or duplication.
- Empty run: start then run_end next cycle with no results -> no write strobe, done within 3 cycles, wr_count=0.
- Wrap: base_addr=0xFFE, 3 words -> addresses 0xFFE, 0xFFF, 0x000; addr_wrap=1 after the 0xFFF write; cleared by the next start.
- Ignored controls: start pulsed mid-RUN and run_end pulsed in IDLE -> no state change, address unaffected.
- Reset mid-DRAIN with 2 words buffered -> all outputs 0 immediately; no write after release; new start with base 0x000 behaves as a fresh run.

Source files
------------

// File: rtl/output_write_scheduler_pkg.sv
// Shared types and constants for the output write scheduler.
// Holds the FSM state encoding and the default widths/base address.
package output_write_scheduler_pkg;

  localparam int OWS_DATA_W = 16;
  localparam int OWS_ADDR_W = 12;

  localparam logic [OWS_ADDR_W-1:0] RUN_BASE_ADDR = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/output_write_scheduler_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; count ranges 0..DEPTH.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module output_write_scheduler_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries data only, so it is not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/output_write_scheduler.sv
// Buffers convolution results and writes them to the output SRAM port
// at consecutive addresses whenever the port is granted; pulses done after draining.
module output_write_scheduler
  import output_write_scheduler_pkg::*;
#(
  parameter int DATA_W = OWS_DATA_W,
  parameter int ADDR_W = OWS_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              run_end,
  input  logic              sram_grant,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              busy,
  output logic              done,
  output logic              addr_wrap
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_next;
  logic              push;
  logic              pop;
  logic              run_active;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] fifo_head;
  logic [ADDR_W-1:0] next_addr;

  assign run_active = (state == ST_RUN) || (state == ST_DRAIN);
  assign push       = res_valid && res_ready && !fifo_full;
  assign pop        = !fifo_empty && sram_grant && run_active;
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  output_write_scheduler_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (push),
    .push_data (res_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)      state_next = ST_RUN;
      ST_RUN:   if (run_end)    state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Ready looks at the post-edge count, so a same-cycle pop never opens a slot early
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) res_ready <= 1'b0;
    else          res_ready <= (state_next == ST_RUN) && (count_next < CW'(DEPTH));
  end

  // Write stage: FIFO head -> registered SRAM write port
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dut_sram_write_enable  <= 1'b0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      next_addr              <= ADDR_W'(RUN_BASE_ADDR);
      wr_count               <= '0;
      addr_wrap              <= 1'b0;
    end else begin
      dut_sram_write_enable <= pop;
      if ((state == ST_IDLE) && start) begin
        next_addr <= base_addr;
        wr_count  <= '0;
        addr_wrap <= 1'b0;
      end else if (pop) begin
        dut_sram_write_address <= next_addr;
        dut_sram_write_data    <= fifo_head;
        next_addr              <= next_addr + ADDR_W'(1);
        wr_count               <= wr_count + ADDR_W'(1);
        if (&next_addr) addr_wrap <= 1'b1;
      end
    end
  end

endmodule
